comp_arbiter: RTL and testbench

COMP_ARBITER -- requirements
Module: comp_arbiter

---
 rtl/comp_arbiter_pkg.sv | 30 +++
 rtl/comp_32.sv | 16 +
 rtl/comp_arbiter.sv | 107 ++++++++++
 tb/tb_comp_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_arbiter_pkg.sv
// Shared definitions for the compare arbiter: FSM encoding, requester ids
// and the round-robin pick function.
package comp_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COMPARE = ST_COMPARE,
        RESP    = ST_RESP
    } state_t;

    // Both pending: hand the slot to whoever did not win last time.
    // Otherwise the single pending requester wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return (last == ID_REQ0) ? ID_REQ1 : ID_REQ0;
        end else if (v0) begin
            return ID_REQ0;
        end else begin
            return ID_REQ1;
        end
    endfunction

endpackage

// File: rtl/comp_32.sv
// 32-bit signed comparator; outputs are forced low when not enabled.
module comp_32 (
    input  logic        enable,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq,
    output logic        gt
);

    // Signed equality / greater-than, gated by enable
    always_comb begin
        eq = enable && (a == b);
        gt = enable && ($signed(a) > $signed(b));
    end

endmodule

// File: rtl/comp_arbiter.sv
// Shares one signed comparator between two requesters with round-robin
// arbitration; result is held until the consumer acknowledges it.
module comp_arbiter
    import comp_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_eq,
    output logic             resp_gt,
    output logic             resp_lt,
    input  logic             resp_ack,
    output logic [CNT_W-1:0] done_count
);

    state_t      state;
    logic        last_grant;
    logic        cur_id;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        any_valid;
    logic        grant_id;
    logic        cmp_eq;
    logic        cmp_gt;

    // Grant decision and ready strobes; only offered while idle
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        any_valid  = req0_valid || req1_valid;
        grant_id   = rr_pick(req0_valid, req1_valid, last_grant);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && any_valid) begin
            req0_ready = (grant_id == ID_REQ0);
            req1_ready = (grant_id == ID_REQ1);
        end
    end

    comp_32 u_comp (
        .enable (state == COMPARE),
        .a      (op_a),
        .b      (op_b),
        .eq     (cmp_eq),
        .gt     (cmp_gt)
    );

    // FSM: accept in IDLE, capture compare result, present until acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_REQ1;
            cur_id     <= ID_REQ0;
            op_a       <= '0;
            op_b       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= ID_REQ0;
            resp_eq    <= 1'b0;
            resp_gt    <= 1'b0;
            resp_lt    <= 1'b0;
            done_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a       <= (grant_id == ID_REQ1) ? req1_a : req0_a;
                        op_b       <= (grant_id == ID_REQ1) ? req1_b : req0_b;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    resp_eq <= cmp_eq;
                    resp_gt <= cmp_gt;
                    resp_lt <= !cmp_eq && !cmp_gt;
                    resp_id <= cur_id;
                    state   <= RESP;
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ack) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                        if (done_count != '1) begin
                            done_count <= done_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter: a scoreboard queue is filled by the
// stimulus tasks and drained by an independent monitor on resp_valid rises.
module tb_comp_arbiter;
    import comp_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        resp_ack = 1'b0;

    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_eq, resp_gt, resp_lt;
    logic [15:0] done_count;
    logic        s_req0_ready, s_req1_ready, s_resp_valid, s_resp_id, s_resp_eq, s_resp_gt, s_resp_lt;
    logic [1:0]  s_done_count;

    comp_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_eq(resp_eq), .resp_gt(resp_gt),
        .resp_lt(resp_lt), .resp_ack(resp_ack), .done_count(done_count)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation
    comp_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_req1_ready),
        .resp_valid(s_resp_valid), .resp_id(s_resp_id), .resp_eq(s_resp_eq), .resp_gt(s_resp_gt),
        .resp_lt(s_resp_lt), .resp_ack(resp_ack), .done_count(s_done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic id;
        logic eq;
        logic gt;
        logic lt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_done = 0;
    int   exp_done_s = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bump_done();
        exp_done++;
        exp_done_s = (exp_done_s == 3) ? 3 : exp_done_s + 1;
    endtask

    task automatic drive_req(input logic which, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (which == ID_REQ0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_done = 0;
        exp_done_s = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One transaction from a single requester, with latency and hold checks
    task automatic run_one(input logic which, input logic [31:0] a, input logic [31:0] b,
                           input logic eid, input logic eeq, input logic egt, input logic elt,
                           input int hold, input bit early);
        exp_t e;
        bit   found;
        e.id = eid; e.eq = eeq; e.gt = egt; e.lt = elt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive_req(which, 1'b1, a, b);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if ((which == ID_REQ1) ? req1_ready : req0_ready) found = 1'b1;
        end
        if (!found) begin
            check("grant_timeout", 0, 1);
            drive_req(which, 1'b0, a, b);
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        drive_req(which, 1'b0, a, b);
        resp_ack = early;
        @(negedge clk);
        check("lat_after_n", resp_valid, 0);
        check("ready_in_compare", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("lat_after_n1", resp_valid, 0);
        @(negedge clk);
        check("lat_after_n2", resp_valid, 1);
        resp_ack = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_ready", {req0_ready, req1_ready}, 0);
            check("hold_result", {resp_id, resp_eq, resp_gt, resp_lt}, {eid, eeq, egt, elt});
            check("hold_count", done_count, exp_done);
        end
        resp_ack = 1'b1;
        @(posedge clk); #1;
        resp_ack = 1'b0;
        bump_done();
        @(negedge clk);
        check("ack_clears_valid", resp_valid, 0);
        check("done_count", done_count, exp_done);
        check("done_count_narrow", s_done_count, exp_done_s);
    endtask

    // Both requesters held valid; grants must alternate 0,1,0
    task automatic run_rr();
        bit   found;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.id = (k == 1) ? ID_REQ1 : ID_REQ0; e.eq = 1'b1; e.gt = 1'b0; e.lt = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        drive_req(ID_REQ0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        drive_req(ID_REQ1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        for (int k = 0; k < 3; k++) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) found = 1'b1;
            end
            if (!found) begin
                check("rr_grant_timeout", 0, 1);
                break;
            end
            check("rr_grant_req1", req1_ready, (k == 1));
            check("rr_grant_req0", req0_ready, (k != 1));
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (resp_valid) found = 1'b1;
            end
            if (!found) begin
                check("rr_resp_timeout", 0, 1);
                break;
            end
            resp_ack = 1'b1;
            @(posedge clk); #1;
            resp_ack = 1'b0;
            bump_done();
            if (k == 2) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("rr_done_count", done_count, exp_done);
    endtask

    // Reset lands while the compare is in flight
    task automatic run_reset_in_compare();
        bit found;
        @(posedge clk); #1;
        drive_req(ID_REQ0, 1'b1, 32'd1, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req0_ready) found = 1'b1;
        end
        if (!found) check("rst_grant_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        exp_done = 0;
        exp_done_s = 0;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_done_count", done_count, 0);
        check("rst_done_narrow", s_done_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_resp", resp_valid, 0);
        end
        // IDLE shows as an immediate ready; valid is withdrawn before any edge
        req1_valid = 1'b1;
        #1;
        check("rst_back_to_idle", req1_ready, 1);
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dropped_valid_no_resp", resp_valid, 0);
        end
    endtask

    // Monitor: compare against the scoreboard on every resp_valid rise
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                check("ready_exclusive", req0_ready && req1_ready, 0);
                if (resp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id", resp_id, e.id);
                        check("resp_eq", resp_eq, e.eq);
                        check("resp_gt", resp_gt, e.gt);
                        check("resp_lt", resp_lt, e.lt);
                        check("resp_onehot", $countones({resp_eq, resp_gt, resp_lt}), 1);
                    end
                end
                prev_valid = resp_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_id", resp_id, 0);
        check("reset_results", {resp_eq, resp_gt, resp_lt}, 0);
        check("reset_done_count", done_count, 0);
        check("reset_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_one(ID_REQ0, 32'd5,          32'd3,          ID_REQ0, 0, 1, 0, 0, 0);
        run_one(ID_REQ1, 32'hFFFF_FFFF,  32'h0000_0001,  ID_REQ1, 0, 0, 1, 0, 0);
        run_one(ID_REQ0, 32'd7,          32'd7,          ID_REQ0, 1, 0, 0, 5, 0);
        run_one(ID_REQ1, 32'h7FFF_FFFF,  32'h8000_0000,  ID_REQ1, 0, 1, 0, 1, 1);
        run_one(ID_REQ0, 32'h8000_0000,  32'h7FFF_FFFF,  ID_REQ0, 0, 0, 1, 0, 0);

        do_reset();
        run_rr();

        do_reset();
        run_one(ID_REQ0, 32'd9,          32'd4,          ID_REQ0, 0, 1, 0, 5, 0);
        check("ack_after_hold_count", done_count, 1);

        run_reset_in_compare();

        run_one(ID_REQ0, 32'd10,         32'hFFFF_FFF6,  ID_REQ0, 0, 1, 0, 0, 0);
        run_one(ID_REQ1, 32'hFFFF_FFF6,  32'd10,         ID_REQ1, 0, 0, 1, 0, 0);
        run_one(ID_REQ0, 32'd0,          32'd0,          ID_REQ0, 1, 0, 0, 0, 0);
        run_one(ID_REQ1, 32'h8000_0000,  32'h8000_0001,  ID_REQ1, 0, 0, 1, 0, 0);
        run_one(ID_REQ0, 32'd1,          32'd0,          ID_REQ0, 0, 1, 0, 0, 0);
        check("saturated_narrow", s_done_count, 3);
        check("wide_count_five", done_count, 5);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
